// File: rtl/icache_dm.sv
// Direct-mapped instruction cache between fetch PC logic and a word-wide backing memory.
// Latency: hit 1 cycle; miss WORDS_PER_LINE memory beats + 2 cycles (line refill, then respond).
// Backpressure: fetch stalls (cpu_ready low) during refill; refill waits indefinitely on mem_valid.
// Ports: clock/reset (sync, active-high); cpu_req/cpu_addr in, cpu_ready/cpu_instr out;
//        flush pulse; mem_req/mem_addr out, mem_rdata/mem_valid in; saturating hit/miss counters.
module icache_dm #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              flush,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_instr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int OFF   = $clog2(WORDS_PER_LINE);
  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX - OFF - 2;

  typedef enum logic [1:0] {IDLE, REFILL, RESPOND} state_t;

  state_t            state;
  logic [DATA_W-1:0] data_mem [LINES][WORDS_PER_LINE];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINES-1:0]  valid;

  // Request being refilled, captured at miss time.
  logic [IDX-1:0]    r_idx;
  logic [TAG_W-1:0]  r_tag;
  logic [OFF-1:0]    r_word;
  logic [OFF-1:0]    cnt;
  logic              flush_pend;

  // Address split of the incoming fetch address; byte offset is irrelevant for 4-byte words.
  logic [OFF-1:0]    a_word;
  logic [IDX-1:0]    a_idx;
  logic [TAG_W-1:0]  a_tag;
  logic              a_hit;
  logic [1:0]        unused_byte_off;

  assign a_word          = cpu_addr[OFF+1:2];
  assign a_idx           = cpu_addr[OFF+IDX+1:OFF+2];
  assign a_tag           = cpu_addr[ADDR_W-1:OFF+IDX+2];
  assign a_hit           = valid[a_idx] && (tag_mem[a_idx] == a_tag);
  assign unused_byte_off = cpu_addr[1:0];

  // Line storage: no reset needed, validity is tracked separately.
  always_ff @(posedge clock) begin
    if (!reset && state == REFILL && mem_valid) begin
      data_mem[r_idx][cnt] <= mem_rdata;
      if (&cnt) tag_mem[r_idx] <= r_tag;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      valid      <= '0;
      cnt        <= '0;
      flush_pend <= 1'b0;
      r_idx      <= '0;
      r_tag      <= '0;
      r_word     <= '0;
      cpu_ready  <= 1'b0;
      cpu_instr  <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (flush || flush_pend) begin
            // Flush owns this cycle; any request is looked up again next cycle.
            valid      <= '0;
            flush_pend <= 1'b0;
          end else if (cpu_req && !cpu_ready) begin
            // The cycle carrying cpu_ready still sees the old request held; skip it.
            if (a_hit) begin
              cpu_ready <= 1'b1;
              cpu_instr <= data_mem[a_idx][a_word];
              if (hit_count != '1) hit_count <= hit_count + 32'd1;
            end else begin
              if (miss_count != '1) miss_count <= miss_count + 32'd1;
              valid[a_idx] <= 1'b0;
              cnt          <= '0;
              r_idx        <= a_idx;
              r_tag        <= a_tag;
              r_word       <= a_word;
              mem_req      <= 1'b1;
              mem_addr     <= {a_tag, a_idx, {(OFF+2){1'b0}}};
              state        <= REFILL;
            end
          end
        end
        REFILL: begin
          if (flush) flush_pend <= 1'b1;
          if (mem_valid) begin
            cnt <= cnt + 1'b1;
            if (&cnt) begin
              valid[r_idx] <= 1'b1;
              mem_req      <= 1'b0;
              state        <= RESPOND;
            end else begin
              mem_addr <= mem_addr + ADDR_W'(4);
            end
          end
        end
        RESPOND: begin
          if (flush) flush_pend <= 1'b1;
          cpu_ready <= 1'b1;
          cpu_instr <= data_mem[r_idx][r_word];
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Testbench for icache_dm: directed table, hand sequences for flush/reset corners, random fetches.
// Latency: n/a (bench).
// Backpressure: backing memory model inserts a programmable number of idle cycles per beat.
module tb_icache_dm;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        flush;
  logic        cpu_ready;
  logic [31:0] cpu_instr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  icache_dm dut (
    .clock(clock), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .flush(flush),
    .cpu_ready(cpu_ready), .cpu_instr(cpu_instr), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Backing memory: word(a) = a ^ K, one beat after mem_gap idle cycles.
  int          mem_gap = 0;
  bit          spur_en = 0;
  logic [31:0] beat_q[$];

  initial begin
    int gap_cnt;
    gap_cnt   = 0;
    mem_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (mem_req) begin
        if (gap_cnt >= mem_gap) begin
          mem_valid = 1'b1;
          mem_rdata = mem_addr ^ K;
          beat_q.push_back(mem_addr);
          gap_cnt   = 0;
        end else begin
          mem_valid = 1'b0;
          mem_rdata = $urandom;
          gap_cnt++;
        end
      end else begin
        gap_cnt   = 0;
        mem_valid = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata = $urandom;
      end
    end
  end

  // Reference model: which tag each line holds, plus expected counters.
  bit          m_valid[16];
  logic [23:0] m_tag[16];
  int          e_hits = 0;
  int          e_miss = 0;

  function automatic bit m_access(input logic [31:0] a);
    int i;
    i = int'(a[7:4]);
    if (m_valid[i] && m_tag[i] == a[31:8]) begin
      e_hits++;
      return 1'b1;
    end
    m_valid[i] = 1'b1;
    m_tag[i]   = a[31:8];
    e_miss++;
    return 1'b0;
  endfunction

  function automatic void m_flush();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endfunction

  // One fetch transaction; returns instruction, latency in cycles and beats seen.
  task automatic fetch(input logic [31:0] a, input int gap, output logic [31:0] instr,
                       output int lat, output int nbeats);
    mem_gap = gap;
    beat_q.delete();
    @(negedge clock);
    cpu_req  = 1'b1;
    cpu_addr = a;
    lat      = 0;
    while (lat < 400) begin
      @(negedge clock);
      lat++;
      if (cpu_ready) break;
    end
    if (!cpu_ready) $display("FAIL fetch_timeout: addr %0h no cpu_ready", a);
    instr   = cpu_instr;
    cpu_req = 1'b0;
    nbeats  = beat_q.size();
  endtask

  // Checks a fetch outcome against expectations, including refill address order.
  task automatic check_fetch(input string tag, input logic [31:0] a, input bit miss,
                             input logic [31:0] instr, input int lat, input int nbeats,
                             input logic [31:0] e_instr, input int e_lat);
    chk({tag, "_instr"}, instr, e_instr);
    chk({tag, "_lat"}, lat, e_lat);
    chk({tag, "_beats"}, nbeats, miss ? 4 : 0);
    if (miss && nbeats == 4)
      for (int i = 0; i < 4; i++)
        chk({tag, "_beat_addr"}, beat_q[i], {a[31:4], 4'h0} + 32'(4 * i));
  endtask

  typedef struct {
    logic [31:0] addr;
    int          gap;
    bit          miss;
    logic [31:0] instr;
    int          lat;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [31:0] instr;
    int          lat, nb, n;
    bit          hit;
    logic [31:0] a;

    tbl[0] = '{32'h0000_0010, 0, 1'b1, 32'hA5A5_0010, 6};
    tbl[1] = '{32'h0000_0018, 0, 1'b0, 32'hA5A5_0018, 1};
    tbl[2] = '{32'h0000_0110, 0, 1'b1, 32'hA5A5_0110, 6};
    tbl[3] = '{32'h0000_0010, 0, 1'b1, 32'hA5A5_0010, 6};
    tbl[4] = '{32'h0000_0204, 3, 1'b1, 32'hA5A5_0204, 18};
    tbl[5] = '{32'h0000_020C, 1, 1'b0, 32'hA5A5_020C, 1};
    tbl[6] = '{32'h0000_001B, 0, 1'b0, 32'hA5A5_0018, 1};

    reset    = 1'b1;
    cpu_req  = 1'b0;
    cpu_addr = '0;
    flush    = 1'b0;
    m_flush();
    repeat (3) @(negedge clock);
    chk("rst_ready", cpu_ready, 0);
    chk("rst_instr", cpu_instr, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_miss", miss_count, 0);
    reset   = 1'b0;
    spur_en = 1'b1;

    // Directed table: cold miss, hit, aliasing evictions, slow memory.
    for (int i = 0; i < 7; i++) begin
      fetch(tbl[i].addr, tbl[i].gap, instr, lat, nb);
      hit = m_access(tbl[i].addr);
      check_fetch("tbl", tbl[i].addr, tbl[i].miss, instr, lat, nb, tbl[i].instr, tbl[i].lat);
      if (i == 0) chk("tbl_first_miss_count", miss_count, 1);
      if (i == 3) chk("tbl_alias_miss_count", miss_count, 3);
    end
    chk("tbl_hits", hit_count, 3);
    chk("tbl_miss", miss_count, 4);

    // Flush in IDLE, then a previously cached word misses.
    @(negedge clock); flush = 1'b1;
    @(negedge clock); flush = 1'b0;
    m_flush();
    fetch(32'h14, 0, instr, lat, nb);
    hit = m_access(32'h14);
    check_fetch("idle_flush", 32'h14, 1'b1, instr, lat, nb, 32'hA5A5_0014, 6);

    // Flush mid-refill: response still delivered, then the line is gone.
    mem_gap = 1;
    beat_q.delete();
    @(negedge clock); cpu_req = 1'b1; cpu_addr = 32'h30;
    repeat (3) @(negedge clock);
    flush = 1'b1;
    @(negedge clock); flush = 1'b0;
    n = 0;
    while (!cpu_ready && n < 100) begin @(negedge clock); n++; end
    chk("refill_flush_ready", cpu_ready, 1);
    chk("refill_flush_instr", cpu_instr, 32'hA5A5_0030);
    chk("refill_flush_beats", beat_q.size(), 4);
    cpu_req = 1'b0;
    hit = m_access(32'h30);
    m_flush();
    fetch(32'h34, 0, instr, lat, nb);
    hit = m_access(32'h34);
    check_fetch("after_pend_flush", 32'h34, 1'b1, instr, lat, nb, 32'hA5A5_0034, 6);
    chk("pend_flush_miss", miss_count, e_miss);

    // Reset during the second refill beat aborts; line refilled from scratch afterwards.
    mem_gap = 0;
    beat_q.delete();
    @(negedge clock); cpu_req = 1'b1; cpu_addr = 32'h50;
    n = 0;
    while (beat_q.size() < 2 && n < 50) begin @(negedge clock); #1; n++; end
    reset   = 1'b1;
    cpu_req = 1'b0;
    @(negedge clock);
    chk("abort_ready", cpu_ready, 0);
    chk("abort_instr", cpu_instr, 0);
    chk("abort_mem_req", mem_req, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_hits", hit_count, 0);
    chk("abort_miss", miss_count, 0);
    reset = 1'b0;
    m_flush();
    e_hits = 0;
    e_miss = 0;
    fetch(32'h50, 0, instr, lat, nb);
    hit = m_access(32'h50);
    check_fetch("after_abort", 32'h50, 1'b1, instr, lat, nb, 32'hA5A5_0050, 6);

    // Random fetches against the reference model.
    for (int it = 0; it < 200; it++) begin
      int g;
      a = {22'($urandom_range(0, 3)), 4'($urandom), 2'($urandom), 2'($urandom), 2'($urandom)};
      a = {a[31:10] == 0 ? 24'($urandom_range(0, 3)) : 24'(0), a[7:0]};
      g = $urandom_range(0, 2);
      if ($urandom_range(0, 15) == 0) begin
        @(negedge clock); flush = 1'b1;
        @(negedge clock); flush = 1'b0;
        m_flush();
      end
      fetch(a, g, instr, lat, nb);
      hit = m_access(a);
      check_fetch("rand", a, !hit, instr, lat, nb, {a[31:2], 2'b00} ^ K,
                  hit ? 1 : 2 + 4 * (g + 1));
      chk("rand_hits", hit_count, e_hits);
      chk("rand_miss", miss_count, e_miss);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Parametrised direct-mapped instruction cache, the successor to the flat instruction ROM in the fetch (F) stage.
- Sits between the fetch PC logic and a word-wide backing instruction memory.
- Serves hits from on-chip line storage. On a miss, refills a full line from backing memory over a req/valid handshake and stalls fetch meanwhile.
- Provides a flush command and hit/miss performance counters.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, instruction/word width. Fixed 4-byte words; addr[1:0] is ignored.
- LINES, 16, number of cache lines. Power of two, >= 2.
- WORDS_PER_LINE, 4, words per line. Power of two, >= 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  fetch request. Held high with addr stable until cpu_ready.
- cpu_addr  in  ADDR_W  byte address of the instruction.
- flush  in  1  invalidate all lines (single-cycle pulse).
- cpu_ready  out  1  one-cycle pulse: cpu_instr is valid.
- cpu_instr  out  DATA_W  fetched instruction.
- mem_req  out  1  refill word request to backing memory.
- mem_addr  out  ADDR_W  word-aligned refill address.
- mem_rdata  in  DATA_W  refill data.
- mem_valid  in  1  mem_rdata valid for the current mem_addr.
- hit_count  out  32  saturating hit counter.
- miss_count  out  32  saturating miss counter.

Behaviour:
- Address split, with OFF=log2(WORDS_PER_LINE) and IDX=log2(LINES):
  - word select = addr[OFF+1:2]
  - index = addr[OFF+IDX+1:OFF+2]
  - tag = the remaining upper bits
  - Defaults: word [3:2], index [7:4], tag [31:8].
- Storage is three registered arrays: data (LINES×WORDS_PER_LINE×DATA_W), tag, and a valid bit per line.
- Reset (synchronous):
  - all valid bits cleared, state=IDLE, word counter=0;
  - cpu_ready=0, cpu_instr=0, mem_req=0, mem_addr=0, hit_count=0, miss_count=0.
  - Reset asserted mid-refill aborts the refill immediately; the partially filled line stays invalid.
- FSM states: IDLE, REFILL, RESPOND.
- IDLE:
  - flush=1 clears all valid bits this edge and ignores cpu_req this cycle (flush has priority).
  - Else, cpu_req=1 with valid[index] and tag match is a hit:
    - next edge drives cpu_ready=1 and cpu_instr=data[index][word];
    - hit_count increments;
    - stays in IDLE;
    - hit latency is 1 cycle.
  - Else, cpu_req=1 is a miss:
    - miss_count increments;
    - valid[index] cleared;
    - word counter=0;
    - mem_req=1 and mem_addr = {tag,index,0...} (line base);
    - go to REFILL.
- REFILL:
  - mem_req stays 1. The cache waits indefinitely for mem_valid.
  - Each cycle mem_valid=1 writes mem_rdata into data[index][counter], increments the counter, and sets mem_addr to the next word.
  - On the last word (counter=WORDS_PER_LINE-1 with mem_valid):
    - write the tag, set valid[index];
    - mem_req=0, mem_addr holds;
    - go to RESPOND.
  - The refill always starts at word 0 (no critical-word-first).
- RESPOND:
  - cpu_ready=1 with the requested word for one cycle, then return to IDLE.
  - Miss latency = WORDS_PER_LINE memory beats + 2 cycles.
- cpu_ready is 0 in every cycle not listed above. cpu_instr holds its last value when cpu_ready=0.
- A flush received in REFILL or RESPOND is latched as pending:
  - the refill completes and the response is delivered;
  - on the next IDLE cycle all valid bits are cleared and pending is consumed;
  - that IDLE cycle does not serve cpu_req, which is re-looked-up on the following cycle.
- Back-to-back requests: the cpu may change addr in the cycle after cpu_ready. A new request is looked up in the first IDLE cycle it is present, so sustained hits give one instruction every 2 cycles (req→ready, ready cycle consumed).
- Counters saturate at 0xFFFF_FFFF and never wrap.
- mem_valid while mem_req=0 is ignored.
- Index aliasing (same index, different tag) evicts unconditionally. The cache is read-only, so no write-back.

Test Plan:
1. Reset, then cpu_req addr=0x0000_0010 with backing mem word(a)=a^0xA5A5_0000 and mem_valid every cycle → mem_req for 0x10, 0x14, 0x18, 0x1C; cpu_ready at cycle 6 with 0xA5A5_0010; miss_count=1.
2. Then request 0x18 → cpu_ready on the next cycle with 0xA5A5_0018, no mem_req, hit_count=1.
3. Request 0x110 (same index 1, tag 1) → miss, refill 0x110–0x11C; then 0x10 → misses again; miss_count=3.
4. After a fill, pulse flush in IDLE, then request 0x14 → miss (mem_req asserted). Flush pulsed mid-REFILL → the current response still delivered, and a following request to the same line misses.
5. Insert 3 idle cycles between mem_valid beats → no spurious cpu_ready, counter advances only on mem_valid, correct line data.
6. Assert reset during REFILL beat 2 → all outputs 0 next cycle; the re-request to the same address misses and refills all 4 words.
